// File: rtl/exec_pkg.sv
// Shared constants, opcode map and opcode validity check for the EX stage.
package exec_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int IMMW = 10;
  localparam int OPW  = 7;

  localparam logic [OPW-1:0] OP_ADD  = 7'h00;
  localparam logic [OPW-1:0] OP_SUB  = 7'h01;
  localparam logic [OPW-1:0] OP_MUL  = 7'h02;
  localparam logic [OPW-1:0] OP_AND  = 7'h03;
  localparam logic [OPW-1:0] OP_OR   = 7'h04;
  localparam logic [OPW-1:0] OP_XOR  = 7'h05;
  localparam logic [OPW-1:0] OP_SLL  = 7'h06;
  localparam logic [OPW-1:0] OP_SRL  = 7'h07;
  localparam logic [OPW-1:0] OP_SRA  = 7'h08;
  localparam logic [OPW-1:0] OP_SLT  = 7'h09;
  localparam logic [OPW-1:0] OP_ADDI = 7'h0A;
  localparam logic [OPW-1:0] OP_LDB  = 7'h10;
  localparam logic [OPW-1:0] OP_LDW  = 7'h11;
  localparam logic [OPW-1:0] OP_STB  = 7'h12;
  localparam logic [OPW-1:0] OP_STW  = 7'h13;
  localparam logic [OPW-1:0] OP_MOV  = 7'h14;

  // True for every opcode the EX stage implements; anything else becomes a no-op.
  function automatic logic is_valid_opcode(input logic [OPW-1:0] op);
    return (op <= OP_ADDI) || ((op >= OP_LDB) && (op <= OP_MOV));
  endfunction

endpackage

// File: rtl/execution_alu.sv
// Combinational ALU / address generator for the EX stage.
module execution_alu
  import exec_pkg::*;
(
  input  logic [OPW-1:0]  opcode,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] alu_out,
  output logic            valid
);

  logic [4:0] shamt;
  assign shamt = src2[4:0];

  // Opcode decode; unsupported opcodes give zero and deassert valid.
  always_comb begin
    alu_out = '0;
    valid   = is_valid_opcode(opcode);
    unique case (opcode)
      OP_ADD:  alu_out = src1 + src2;
      OP_SUB:  alu_out = src1 - src2;
      OP_MUL:  alu_out = src1 * src2;
      OP_AND:  alu_out = src1 & src2;
      OP_OR:   alu_out = src1 | src2;
      OP_XOR:  alu_out = src1 ^ src2;
      OP_SLL:  alu_out = src1 << shamt;
      OP_SRL:  alu_out = src1 >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(src1) >>> shamt);
      OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_ADDI,
      OP_LDB,
      OP_LDW,
      OP_STB,
      OP_STW:  alu_out = src1 + imm;
      OP_MOV:  alu_out = src1;
      default: alu_out = '0;
    endcase
  end

endmodule

// File: rtl/execution_stage.sv
// EX pipeline stage: sign-extends the immediate, runs the ALU and registers
// result and destination index with a single cycle of latency.
module execution_stage
  import exec_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic [REGW-1:0] dstin,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [IMMW-1:0] offsetlo,
  output logic [XLEN-1:0] result,
  output logic [REGW-1:0] dstout
);

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_out;
  logic            valid;
  logic [XLEN-1:0] result_d, result_q;
  logic [REGW-1:0] dst_d, dst_q;

  assign imm = {{(XLEN-IMMW){offsetlo[IMMW-1]}}, offsetlo};

  execution_alu u_alu (
    .opcode  (opcode),
    .src1    (src1),
    .src2    (src2),
    .imm     (imm),
    .alu_out (alu_out),
    .valid   (valid)
  );

  // Invalid opcodes retarget writeback to r0 with a zero result.
  always_comb begin
    result_d = valid ? alu_out : '0;
    dst_d    = valid ? dstin   : '0;
  end

  // Output register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      dst_q    <= '0;
    end else begin
      result_q <= result_d;
      dst_q    <= dst_d;
    end
  end

  assign result = result_q;
  assign dstout = dst_q;

endmodule

// File: tb/tb_execution_stage.sv
// Directed bench for the EX stage with hand-computed expected values.
module tb_execution_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [4:0]  dstin = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [9:0]  offsetlo = '0;
  logic [31:0] result;
  logic [4:0]  dstout;

  int total = 0;
  int passed = 0;

  execution_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .dstin    (dstin),
    .src1     (src1),
    .src2     (src2),
    .offsetlo (offsetlo),
    .result   (result),
    .dstout   (dstout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Apply one operation and step past the capturing edge.
  task automatic run(input logic [6:0] op, input logic [4:0] d, input logic [31:0] a,
                     input logic [31:0] b, input logic [9:0] off);
    opcode = op; dstin = d; src1 = a; src2 = b; offsetlo = off;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state, including an edge while held in reset with live inputs.
    opcode = 7'h00; dstin = 5'd7; src1 = 32'd1; src2 = 32'd2;
    #3;
    check("rst_result", result, 32'h0);
    check("rst_dstout", {27'b0, dstout}, 32'd0);
    @(posedge clk); #1;
    check("rst_hold_result", result, 32'h0);
    check("rst_hold_dstout", {27'b0, dstout}, 32'd0);
    rst_n = 1'b1;

    // ADD then SUB back to back.
    run(7'h00, 5'd3, 32'd20, 32'd10, 10'h0);
    check("add_result", result, 32'h0000001E);
    check("add_dstout", {27'b0, dstout}, 32'd3);
    run(7'h01, 5'd3, 32'd20, 32'd10, 10'h0);
    check("sub_result", result, 32'h0000000A);
    check("sub_dstout", {27'b0, dstout}, 32'd3);

    // Async reset mid-cycle while result=30 is held.
    run(7'h00, 5'd3, 32'd20, 32'd10, 10'h0);
    check("pre_rst_result", result, 32'd30);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_result", result, 32'h0);
    check("async_rst_dstout", {27'b0, dstout}, 32'd0);
    @(posedge clk); #2;
    check("rst_edge_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_result", result, 32'd30);
    check("post_rst_dstout", {27'b0, dstout}, 32'd3);

    // Negative SUB result; consecutive ops each produce their own result.
    run(7'h01, 5'd8, 32'd10, 32'd40, 10'h0);
    check("sub_neg_result", result, 32'hFFFFFFE2);
    check("sub_neg_dstout", {27'b0, dstout}, 32'd8);
    run(7'h03, 5'd9, 32'hF0F0_FF00, 32'h0FF0_F0F0, 10'h0);
    check("and_result", result, 32'h00F0_F000);
    check("and_dstout", {27'b0, dstout}, 32'd9);
    run(7'h04, 5'd10, 32'hF0F0_FF00, 32'h0FF0_F0F0, 10'h0);
    check("or_result", result, 32'hFFF0_FFF0);
    run(7'h05, 5'd11, 32'hF0F0_FF00, 32'h0FF0_F0F0, 10'h0);
    check("xor_result", result, 32'hFF00_0FF0);
    check("xor_dstout", {27'b0, dstout}, 32'd11);

    // Sign-extended immediates.
    run(7'h11, 5'd4, 32'd100, 32'd0, 10'h3FF);
    check("ldw_result", result, 32'd99);
    run(7'h0A, 5'd5, 32'd0, 32'd0, 10'h1FF);
    check("addi_result", result, 32'd511);
    run(7'h12, 5'd6, 32'h0000_1000, 32'd0, 10'h200);
    check("stb_result", result, 32'h0000_0E00);

    // Shifts use src2[4:0] only.
    run(7'h08, 5'd1, 32'h8000_0000, 32'h0000_0024, 10'h0);
    check("sra_result", result, 32'hF800_0000);
    run(7'h07, 5'd1, 32'h8000_0000, 32'hFFFF_FFE4, 10'h0);
    check("srl_result", result, 32'h0800_0000);
    run(7'h06, 5'd1, 32'h0000_0003, 32'h0000_0021, 10'h0);
    check("sll_result", result, 32'h0000_0006);

    // Signed compare.
    run(7'h09, 5'd2, 32'hFFFF_FFFF, 32'd1, 10'h0);
    check("slt_true", result, 32'd1);
    run(7'h09, 5'd2, 32'd1, 32'hFFFF_FFFF, 10'h0);
    check("slt_false", result, 32'd0);

    // Invalid opcodes become no-ops targeting r0.
    run(7'h7F, 5'd12, 32'd5, 32'd5, 10'h0);
    check("inv7f_result", result, 32'h0);
    check("inv7f_dstout", {27'b0, dstout}, 32'd0);
    run(7'h0B, 5'd13, 32'd5, 32'd5, 10'h0);
    check("inv0b_result", result, 32'h0);
    check("inv0b_dstout", {27'b0, dstout}, 32'd0);
    run(7'h15, 5'd14, 32'd5, 32'd5, 10'h0);
    check("inv15_dstout", {27'b0, dstout}, 32'd0);

    // MUL keeps only the low 32 bits; MOV passes src1.
    run(7'h02, 5'd15, 32'h0001_0000, 32'h0001_0000, 10'h0);
    check("mul_wrap_result", result, 32'h0);
    check("mul_dstout", {27'b0, dstout}, 32'd15);
    run(7'h02, 5'd15, 32'd1234, 32'd5678, 10'h0);
    check("mul_result", result, 32'd7006652);
    run(7'h14, 5'd31, 32'hDEAD_BEEF, 32'h1, 10'h155);
    check("mov_result", result, 32'hDEAD_BEEF);
    check("mov_dstout", {27'b0, dstout}, 32'd31);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/execution_stage.md
Name: execution_stage

Overview:
- Execute (EX) stage of the in-order integer pipeline; sits between decode/register-read and memory/writeback.
- Takes a decoded opcode, two 32-bit register operands, a 10-bit immediate and a destination register index.
- Computes the ALU or address result and registers it with the destination index for the next stage.

Parameters:
- XLEN, 32, datapath width of src1/src2/result.
- REGW, 5, register index width of dstin/dstout.
- IMMW, 10, immediate (offsetlo) width; always sign-extended to XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  decoded operation code.
- dstin  input  5  destination register index from decode.
- src1  input  32  operand A (rs1 value).
- src2  input  32  operand B (rs2 value).
- offsetlo  input  10  immediate/offset, two's complement.
- result  output  32  registered operation result.
- dstout  output  5  registered destination index.

Behaviour:
- Reset: rst_n low forces result=0 and dstout=0 immediately, without waiting for a clock edge. The outputs hold 0 while rst_n is low. Normal operation starts at the first rising clk edge after rst_n deasserts.
- Latency: 1 cycle. The inputs present at rising edge N appear on result/dstout after edge N. No handshake, no stall; the block accepts a new operation every cycle.
- imm = sign-extend(offsetlo) to 32 bits. All arithmetic is modulo 2^32 with no overflow flag.
- Opcode map (hex):
  - 00 ADD: src1+src2.
  - 01 SUB: src1-src2.
  - 02 MUL: low 32 bits of src1*src2.
  - 03 AND, 04 OR, 05 XOR: bitwise on src1, src2.
  - 06 SLL: src1 << src2[4:0].
  - 07 SRL: src1 >> src2[4:0], logical.
  - 08 SRA: src1 >> src2[4:0], arithmetic.
  - 09 SLT: 1 if signed src1 < signed src2, else 0.
  - 0A ADDI: src1+imm.
  - 10 LDB, 11 LDW, 12 STB, 13 STW: effective address src1+imm.
  - 14 MOV: src1.
- dstout = dstin for every valid opcode.
- Any other opcode: result=0 and dstout=0, so writeback targets r0 and the operation becomes a no-op.
- Shifts use only src2[4:0]; src2[31:5] is ignored.
- The combinational result is computed from the current inputs only. The block does not forward its own registered result.

Decomposition:
- Shared package exec_pkg:
  - opcode localparams (OP_ADD … OP_MOV);
  - XLEN/REGW/IMMW constants;
  - an is_valid_opcode function.
- One combinational sub-module, execution_alu (opcode, src1, src2, imm -> alu_out, valid).
- The top level holds sign extension, the output register and reset.

Test Plan:
- Reset pulse mid-stream with result=30 held → result=0 and dstout=0 asynchronously, before any clk edge. First op after release: opcode=00, src1=20, src2=10, dstin=3 → result=30, dstout=3 after one edge.
- opcode=00, src1=20, src2=10, dstin=3 → result=0x0000001E, dstout=3 after one edge. Next cycle opcode=01 with the same operands → result=0x0000000A, dstout=3.
- opcode=01, src1=10, src2=40, dstin=8 → result=0xFFFFFFE2, dstout=8. Also check back-to-back ops give one result per cycle.
- opcode=11, src1=100, offsetlo=10'h3FF → result=99. opcode=0A, src1=0, offsetlo=10'h1FF → result=511.
- opcode=08, src1=0x80000000, src2=0x00000024 (shift amount 4) → result=0xF8000000. opcode=09, src1=0xFFFFFFFF, src2=1 → result=1.
- opcode=7F, dstin=12, src1=5, src2=5 → result=0, dstout=0. opcode=02, src1=0x10000, src2=0x10000 → result=0.
